// File: rtl/me_pkg.sv
// Shared constants, pixel type and loader state encoding for the ME window loader.
package me_pkg;

    localparam int unsigned DEF_MACRO_DIM  = 16;
    localparam int unsigned DEF_SEARCH_DIM = 48;
    localparam int unsigned PORT_WIDTH     = DEF_MACRO_DIM + 1;
    localparam int unsigned BANK_DEPTH     =
        ((DEF_SEARCH_DIM + PORT_WIDTH - 1) / PORT_WIDTH) * DEF_SEARCH_DIM;
    localparam int unsigned IDX_W          = 16;

    typedef logic [7:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_S = 2'd1,
        LOAD_C = 2'd2,
        READY  = 2'd3
    } loader_state_t;

    // Words per bank: column groups of (md+1) columns, each group holding sd rows.
    function automatic int unsigned bank_depth(input int unsigned md, input int unsigned sd);
        return ((sd + md) / (md + 1)) * sd;
    endfunction

endpackage

// File: rtl/sw_bank.sv
// One column-interleaved search-window bank: synchronous write, asynchronous read.
module sw_bank
    import me_pkg::*;
#(
    parameter int unsigned DEPTH = BANK_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    pixel_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/me_window_loader.sv
// Loads a raster search window + current macroblock and serves them combinationally
// to the motion-estimation core, one row segment per addr/amt request.
module me_window_loader
    import me_pkg::*;
#(
    parameter int unsigned MACRO_DIM  = DEF_MACRO_DIM,
    parameter int unsigned SEARCH_DIM = DEF_SEARCH_DIM
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_start,
    input  logic [7:0]               pix_in,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    output logic                     win_valid,
    input  logic                     win_release,
    input  logic [5:0]               addr,
    input  logic [5:0]               amt,
    output logic [8*(MACRO_DIM+1)-1:0] pixel_spr_out,
    output logic [8*MACRO_DIM-1:0]   pixel_cpr_out
);

    localparam int unsigned PW = MACRO_DIM + 1;
    localparam int unsigned BD = bank_depth(MACRO_DIM, SEARCH_DIM);
    localparam int unsigned AW = $clog2(BD);
    localparam int unsigned BW = $clog2(PW);
    localparam int unsigned MW = (MACRO_DIM > 1) ? $clog2(MACRO_DIM) : 1;

    loader_state_t    state_q, state_d;
    logic [IDX_W-1:0] row_q, row_d, col_q, col_d, grp_q, grp_d;
    logic [BW-1:0]    bank_q, bank_d;
    logic             pix_ready_q, pix_ready_d, win_valid_q, win_valid_d;
    logic             xfer;

    assign xfer      = pix_valid & pix_ready_q;
    assign pix_ready = pix_ready_q;
    assign win_valid = win_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            grp_q       <= '0;
            bank_q      <= '0;
            pix_ready_q <= 1'b0;
            win_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            grp_q       <= grp_d;
            bank_q      <= bank_d;
            pix_ready_q <= pix_ready_d;
            win_valid_q <= win_valid_d;
        end
    end

    // Next state; bank/group track col % PW and col / PW without dividers.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        grp_d   = grp_q;
        bank_d  = bank_q;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD_S;
                    row_d   = '0;
                    col_d   = '0;
                    grp_d   = '0;
                    bank_d  = '0;
                end
            end
            LOAD_S: begin
                if (xfer) begin
                    if (col_q == IDX_W'(SEARCH_DIM - 1)) begin
                        col_d  = '0;
                        grp_d  = '0;
                        bank_d = '0;
                        if (row_q == IDX_W'(SEARCH_DIM - 1)) begin
                            row_d   = '0;
                            state_d = LOAD_C;
                        end else begin
                            row_d = row_q + IDX_W'(1);
                        end
                    end else begin
                        col_d = col_q + IDX_W'(1);
                        if (bank_q == BW'(PW - 1)) begin
                            bank_d = '0;
                            grp_d  = grp_q + IDX_W'(1);
                        end else begin
                            bank_d = bank_q + BW'(1);
                        end
                    end
                end
            end
            LOAD_C: begin
                if (xfer) begin
                    if (col_q == IDX_W'(MACRO_DIM - 1)) begin
                        col_d = '0;
                        if (row_q == IDX_W'(MACRO_DIM - 1)) begin
                            row_d   = '0;
                            state_d = READY;
                        end else begin
                            row_d = row_q + IDX_W'(1);
                        end
                    end else begin
                        col_d = col_q + IDX_W'(1);
                    end
                end
            end
            READY: begin
                if (win_release) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        pix_ready_d = (state_d == LOAD_S) || (state_d == LOAD_C);
        win_valid_d = (state_d == READY);
    end

    logic             we_s;
    logic [AW-1:0]    waddr;
    logic [IDX_W-1:0] amt_mod;
    logic             addr_in_s, addr_in_c;
    logic [AW-1:0]    raddr [PW];
    pixel_t           rdata [PW];

    assign we_s      = xfer && !rst && (state_q == LOAD_S);
    assign waddr     = AW'(grp_q * IDX_W'(SEARCH_DIM) + row_q);
    assign amt_mod   = IDX_W'(amt) % IDX_W'(PW);
    assign addr_in_s = IDX_W'(addr) < IDX_W'(SEARCH_DIM);
    assign addr_in_c = IDX_W'(addr) < IDX_W'(MACRO_DIM);

    // Consecutive columns hit distinct banks, so each bank serves exactly one lane.
    for (genvar b = 0; b < PW; b++) begin : g_bank
        logic [IDX_W-1:0] off, col;
        assign off = (IDX_W'(b) + IDX_W'(PW) - amt_mod) % IDX_W'(PW);
        assign col = IDX_W'(amt) + off;
        assign raddr[b] = (col < IDX_W'(SEARCH_DIM) && addr_in_s)
                        ? AW'((col / IDX_W'(PW)) * IDX_W'(SEARCH_DIM) + IDX_W'(addr))
                        : '0;
        sw_bank #(.DEPTH(BD), .AW(AW)) u_bank (
            .clk     (clk),
            .we_i    (we_s && (bank_q == BW'(b))),
            .waddr_i (waddr),
            .wdata_i (pix_in),
            .raddr_i (raddr[b]),
            .rdata_o (rdata[b])
        );
    end

    for (genvar l = 0; l < PW; l++) begin : g_spr
        logic [IDX_W-1:0] col;
        assign col = IDX_W'(amt) + IDX_W'(l);
        assign pixel_spr_out[8*l +: 8] = (col < IDX_W'(SEARCH_DIM) && addr_in_s)
                                       ? rdata[BW'(col % IDX_W'(PW))] : '0;
    end

    pixel_t cbuf_q [MACRO_DIM][MACRO_DIM];

    // Column-major macroblock buffer: cbuf_q[col][row].
    always_ff @(posedge clk) begin
        if (xfer && !rst && (state_q == LOAD_C)) begin
            cbuf_q[MW'(col_q)][MW'(row_q)] <= pix_in;
        end
    end

    for (genvar l = 0; l < MACRO_DIM; l++) begin : g_cpr
        assign pixel_cpr_out[8*l +: 8] = addr_in_c ? cbuf_q[l][MW'(addr)] : '0;
    end

endmodule
